wheel_step_sequencer: RTL
=========================

WHEEL_STEP_SEQUENCER -- requirements
Module: wheel_step_sequencer

Interface
REQ-001 Parameter NUM_WHEELS, default 2: wheels time-sharing one wheel-update engine.
REQ-002 Parameter SUBSTEPS, default 4: engine passes per wheel per frame.
REQ-003 Parameter TIMEOUT, default 4096: maximum WAIT cycles per engine pass.
REQ-004 Parameter WSEL = max(1, $clog2(NUM_WHEELS)); SSEL = max(1, $clog2(SUBSTEPS)).
REQ-005 Clocking: one clock; reset is synchronous and active-low.
REQ-006 clk_in  input  1  system clock; all logic on rising edge.
REQ-007 rst_in  input  1  synchronous active-low reset (0 = reset).
REQ-008 frame_tick_in  input  1  one-cycle frame-start pulse.
REQ-009 enable_in  input  1  permits starting a new frame.
REQ-010 drive_in  input  3 signed  throttle command, sampled at frame start.
REQ-011 eng_done_in  input  1  engine result pulse.
REQ-012 err_clear_in  input  1  clears sticky error flags.
REQ-013 eng_begin_out  output  1  one-cycle engine start pulse.
REQ-014 eng_wheel_out  output  WSEL  wheel index of current pass.
REQ-015 eng_drive_out  output  3 signed  latched drive for the current frame.
REQ-016 commit_out  output  1  one-cycle strobe; state store latches engine results for commit_wheel_out.
REQ-017 commit_wheel_out  output  WSEL  wheel being committed.
REQ-018 substep_out  output  SSEL  current substep index.
REQ-019 busy_out  output  1  high in every state except IDLE.
REQ-020 frame_done_out  output  1  one-cycle frame-complete pulse.
REQ-021 overrun_out  output  1  sticky: frame tick dropped.
REQ-022 timeout_out  output  1  sticky: engine failed to respond.

Function
REQ-023 States: IDLE, LAUNCH, WAIT, COMMIT, NEXT, DONE. All outputs are Moore decodes of registered state and counters.
REQ-024 IDLE: frame_tick_in && enable_in -> LAUNCH; latch drive_in; wheel=0, substep=0.
REQ-025 LAUNCH: eng_begin_out=1 for exactly this cycle; clear wait timer -> WAIT.
REQ-026 WAIT: eng_done_in=1 -> COMMIT. Otherwise increment timer. The TIMEOUT-th WAIT cycle without done -> set timeout_out, go to IDLE, no frame_done_out.
REQ-027 COMMIT: commit_out=1 and commit_wheel_out=wheel for this cycle -> NEXT.
REQ-028 NEXT, wheel<NUM_WHEELS-1: wheel++ -> LAUNCH.
REQ-029 NEXT, wheel=NUM_WHEELS-1: wheel=0. If substep=SUBSTEPS-1 -> DONE; else substep++ -> LAUNCH.
REQ-030 Pass order: substep-major, wheel-minor (w0,w1,w0,w1...).
REQ-031 DONE: frame_done_out=1 -> IDLE.
REQ-032 Latency: engine response k cycles after begin gives frame_done_out NUM_WHEELS*SUBSTEPS*(k+3)+1 cycles after the tick cycle.
REQ-033 Tick in any non-IDLE state (including DONE): ignored; overrun_out set.
REQ-034 eng_done_in outside WAIT: ignored.
REQ-035 enable_in low mid-frame: the frame completes; only new starts are blocked.
REQ-036 drive_in changes mid-frame: no effect until the next frame start.
REQ-037 err_clear_in clears both sticky flags. A simultaneous set event wins.
REQ-038 Counters never wrap: wheel/substep reset to 0 as stated; timer saturates at TIMEOUT.

Reset
REQ-039 rst_in=0 at a clock edge -> state=IDLE; wheel, substep, timer, latched drive = 0; all outputs 0. This applies mid-frame and discards the frame in progress.
REQ-040 No commit_out or eng_begin_out in the first cycle after rst_in returns to 1.

Structure
REQ-041 Shared physics package holds the state enum typedef and the drive width constant (3).
REQ-042 One sub-module: step_watchdog (timer, clear, saturate, expiry flag).

Verification
REQ-043 NUM_WHEELS=2, SUBSTEPS=2, engine done 5 cycles after begin, tick at cycle 0 -> begins at 1,9,17,25; commit wheels 0,1,0,1; frame_done_out at cycle 33.
REQ-044 TIMEOUT=16, engine silent, tick at 0 -> timeout_out=1 and busy_out=0 at cycle 18; no commit_out; no frame_done_out.
REQ-045 Second tick at cycle 10 of a running frame -> overrun_out=1; the frame finishes normally; err_clear_in -> overrun_out=0.
REQ-046 rst_in=0 during WAIT of pass 3 -> next cycle all outputs 0, state IDLE; a new tick restarts at wheel 0, substep 0.
REQ-047 drive_in=-2 at tick, then 3 mid-frame -> eng_drive_out=-2 for the whole frame; enable_in=0 with a tick -> no start, no overrun.

Source files
------------

// File: rtl/wheel_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wheel_step_sequencer_pkg
// Brief    : Shared physics types: sequencer state encoding and drive width.
// Revision : 1.0
// ============================================================================
package wheel_step_sequencer_pkg;

  localparam int DRIVE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  // Select width with a floor of one bit so single-entry configurations still elaborate.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wheel_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : wheel_step_sequencer_if
// Brief    : Control/engine handshake bundle between frame source and sequencer.
// Revision : 1.0
// ============================================================================
interface wheel_step_sequencer_if
  import wheel_step_sequencer_pkg::*;
#(
  parameter int WSEL = 1,
  parameter int SSEL = 1
);

  logic                      frame_tick_in;
  logic                      enable_in;
  logic signed [DRIVE_W-1:0] drive_in;
  logic                      eng_done_in;
  logic                      err_clear_in;
  logic                      eng_begin_out;
  logic [WSEL-1:0]           eng_wheel_out;
  logic signed [DRIVE_W-1:0] eng_drive_out;
  logic                      commit_out;
  logic [WSEL-1:0]           commit_wheel_out;
  logic [SSEL-1:0]           substep_out;
  logic                      busy_out;
  logic                      frame_done_out;
  logic                      overrun_out;
  logic                      timeout_out;

  modport master (
    output frame_tick_in, enable_in, drive_in, eng_done_in, err_clear_in,
    input  eng_begin_out, eng_wheel_out, eng_drive_out, commit_out,
           commit_wheel_out, substep_out, busy_out, frame_done_out,
           overrun_out, timeout_out
  );

  modport slave (
    input  frame_tick_in, enable_in, drive_in, eng_done_in, err_clear_in,
    output eng_begin_out, eng_wheel_out, eng_drive_out, commit_out,
           commit_wheel_out, substep_out, busy_out, frame_done_out,
           overrun_out, timeout_out
  );

endinterface
`default_nettype wire

// File: rtl/wheel_step_sequencer_step_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : step_watchdog
// Brief    : Per-pass wait timer; saturates at TIMEOUT, flags the final wait cycle.
// Revision : 1.0
// ============================================================================
module step_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  wire logic clk_in,
  input  wire logic rst_in,
  input  wire logic clear,
  input  wire logic count_en,
  output logic      expired
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);
  localparam logic [TW-1:0] FINAL = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (count_en && (timer != LIMIT)) begin
      timer <= timer + TW'(1);
    end
  end

  // High on the TIMEOUT-th consecutive silent wait cycle.
  assign expired = count_en && (timer == FINAL);

endmodule
`default_nettype wire

// File: rtl/wheel_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wheel_step_sequencer
// Brief    : Time-shares one wheel-update engine across wheels and substeps per frame.
// Revision : 1.0
// ============================================================================
module wheel_step_sequencer
  import wheel_step_sequencer_pkg::*;
#(
  parameter int NUM_WHEELS = 2,
  parameter int SUBSTEPS   = 4,
  parameter int TIMEOUT    = 4096,
  parameter int WSEL       = sel_width(NUM_WHEELS),
  parameter int SSEL       = sel_width(SUBSTEPS)
) (
  input wire logic              clk_in,
  input wire logic              rst_in,
  wheel_step_sequencer_if.slave bus
);

  localparam logic [WSEL-1:0] LAST_WHEEL   = WSEL'(NUM_WHEELS - 1);
  localparam logic [SSEL-1:0] LAST_SUBSTEP = SSEL'(SUBSTEPS - 1);

  seq_state_t                state;
  logic [WSEL-1:0]           wheel;
  logic [SSEL-1:0]           substep;
  logic signed [DRIVE_W-1:0] drive;
  logic                      begin_q;
  logic                      commit_q;
  logic [WSEL-1:0]           commit_wheel_q;
  logic                      busy_q;
  logic                      frame_done_q;
  logic                      overrun_q;
  logic                      timeout_q;

  logic wd_clear;
  logic wd_count;
  logic wd_expired;
  logic overrun_set;
  logic timeout_set;

  assign wd_clear    = (state == ST_LAUNCH);
  assign wd_count    = (state == ST_WAIT) && !bus.eng_done_in;
  assign overrun_set = bus.frame_tick_in && (state != ST_IDLE);
  assign timeout_set = wd_expired;

  step_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_step_watchdog (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear    (wd_clear),
    .count_en (wd_count),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state          <= ST_IDLE;
      wheel          <= '0;
      substep        <= '0;
      drive          <= '0;
      begin_q        <= 1'b0;
      commit_q       <= 1'b0;
      commit_wheel_q <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      begin_q        <= 1'b0;
      commit_q       <= 1'b0;
      commit_wheel_q <= '0;
      frame_done_q   <= 1'b0;
      // A set event in the same cycle as a clear keeps the flag high.
      overrun_q      <= overrun_set || (overrun_q && !bus.err_clear_in);
      timeout_q      <= timeout_set || (timeout_q && !bus.err_clear_in);

      case (state)
        ST_IDLE: begin
          if (bus.frame_tick_in && bus.enable_in) begin
            state   <= ST_LAUNCH;
            drive   <= bus.drive_in;
            wheel   <= '0;
            substep <= '0;
            begin_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.eng_done_in) begin
            state          <= ST_COMMIT;
            commit_q       <= 1'b1;
            commit_wheel_q <= wheel;
          end else if (wd_expired) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_COMMIT: begin
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (wheel != LAST_WHEEL) begin
            wheel   <= wheel + WSEL'(1);
            state   <= ST_LAUNCH;
            begin_q <= 1'b1;
          end else begin
            wheel <= '0;
            if (substep == LAST_SUBSTEP) begin
              state        <= ST_DONE;
              frame_done_q <= 1'b1;
            end else begin
              substep <= substep + SSEL'(1);
              state   <= ST_LAUNCH;
              begin_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.eng_begin_out    = begin_q;
  assign bus.eng_wheel_out    = wheel;
  assign bus.eng_drive_out    = drive;
  assign bus.commit_out       = commit_q;
  assign bus.commit_wheel_out = commit_wheel_q;
  assign bus.substep_out      = substep;
  assign bus.busy_out         = busy_q;
  assign bus.frame_done_out   = frame_done_q;
  assign bus.overrun_out      = overrun_q;
  assign bus.timeout_out      = timeout_q;

endmodule
`default_nettype wire
